// File: rtl/alu_pkg.sv
// ALU op-code values, FSM state encoding and op-class decode helpers.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_ORR  = 4'h3;
   localparam logic [3:0] OP_EOR  = 4'h4;
   localparam logic [3:0] OP_RSB  = 4'h5;
   localparam logic [3:0] OP_ADC  = 4'h6;
   localparam logic [3:0] OP_SBC  = 4'h7;
   localparam logic [3:0] OP_RSC  = 4'h8;
   localparam logic [3:0] OP_BIC  = 4'h9;
   localparam logic [3:0] OP_MOV  = 4'hA;
   localparam logic [3:0] OP_MVN  = 4'hB;
   localparam logic [3:0] OP_MUL  = 4'hC;
   localparam logic [3:0] OP_UDIV = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ITER = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Ops that go through the shared WIDTH+1 adder and produce adder C/V.
   function automatic logic is_arith(input logic [3:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC, OP_RSC: is_arith = 1'b1;
         default:                                        is_arith = 1'b0;
      endcase
   endfunction

   // Ops that need the iterative multiply/divide engine.
   function automatic logic is_iter(input logic [3:0] op);
      is_iter = (op == OP_MUL) || (op == OP_UDIV);
   endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative shift-add multiplier (low half) and restoring unsigned divider, 1 bit/cycle.
// Latency: WIDTH iterations after go; last is high during the final iteration cycle.
// Backpressure: none; a go restarts the engine, caller must not pulse go while iterating.
module alu_seq_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             go,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             last,
   output logic [WIDTH-1:0] result
);
   localparam int CNT_W = $clog2(WIDTH + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q, div_d;
   logic [WIDTH-1:0] acc_q, acc_d;    // product accumulator / partial remainder
   logic [WIDTH-1:0] sh_q, sh_d;      // multiplier (shifts right) / dividend->quotient
   logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand (shifts left) / divisor
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   // One multiply or divide step per cycle while the counter is non-zero.
   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      acc_d  = acc_q;
      sh_d   = sh_q;
      opnd_d = opnd_q;
      trial  = {acc_q, sh_q[WIDTH-1]};
      diff   = trial - {1'b0, opnd_q};
      if (go) begin
         cnt_d  = CNT_W'(WIDTH);
         div_d  = is_div;
         acc_d  = '0;
         sh_d   = is_div ? op_a : op_b;
         opnd_d = is_div ? op_b : op_a;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (div_q) begin
            // Restore (keep trial) when the subtraction borrows.
            if (!diff[WIDTH]) begin
               acc_d = diff[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = trial[WIDTH-1:0];
               sh_d  = {sh_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            if (sh_q[0]) begin
               acc_d = acc_q + opnd_q;
            end
            opnd_d = opnd_q << 1;
            sh_d   = sh_q >> 1;
         end
      end
   end

   // Engine state registers.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         cnt_q  <= '0;
         div_q  <= 1'b0;
         acc_q  <= '0;
         sh_q   <= '0;
         opnd_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         opnd_q <= opnd_d;
      end
   end

   assign last = (cnt_q == CNT_W'(1));
   // A zero divisor would leave all-ones in the quotient; report 0 instead.
   assign result = div_q ? ((opnd_q == '0) ? '0 : sh_q) : acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle execute-stage ALU with registered result/NZCV flags and a Start/Done handshake.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MUL/UDIV (accept edge to Done).
// Backpressure: Busy=1 while MUL/UDIV iterates; Start is dropped (not queued) while Busy.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESETn,
   input  logic             Start,
   input  logic [3:0]       ALUOp,
   input  logic [WIDTH-1:0] Src_A,
   input  logic [WIDTH-1:0] Src_B,
   input  logic             C_Flag,
   input  logic             Shifter_carryOut,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUResult,
   output logic [3:0]       ALUFlags
);
   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cf_q, cf_d;
   logic             sc_q, sc_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;

   logic             accept;
   logic             go;
   logic             seq_last;
   logic [WIDTH-1:0] seq_result;
   logic [WIDTH-1:0] add_x, add_y;
   logic             add_cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] res;
   logic             c_out, v_out;

   assign accept = Start && !busy_q;
   assign go     = accept && is_iter(ALUOp);

   alu_seq_muldiv #(.WIDTH(WIDTH)) u_seq (
      .CLK    (CLK),
      .RESETn (RESETn),
      .go     (go),
      .is_div (ALUOp == OP_UDIV),
      .op_a   (Src_A),
      .op_b   (Src_B),
      .last   (seq_last),
      .result (seq_result)
   );

   // Select effective addends and carry-in for the shared adder.
   always_comb begin
      add_x   = a_q;
      add_y   = b_q;
      add_cin = 1'b0;
      case (op_q)
         OP_SUB: begin add_y = ~b_q; add_cin = 1'b1; end
         OP_RSB: begin add_x = b_q; add_y = ~a_q; add_cin = 1'b1; end
         OP_ADC: begin add_cin = cf_q; end
         OP_SBC: begin add_y = ~b_q; add_cin = cf_q; end
         OP_RSC: begin add_x = b_q; add_y = ~a_q; add_cin = cf_q; end
         default: ;
      endcase
      sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
   end

   // Result and C/V for the captured op.
   always_comb begin
      res   = '0;
      c_out = sc_q;
      v_out = 1'b0;
      if (is_arith(op_q)) begin
         res   = sum[WIDTH-1:0];
         c_out = sum[WIDTH];
         v_out = (add_x[WIDTH-1] ~^ add_y[WIDTH-1]) & (add_x[WIDTH-1] ^ sum[WIDTH-1]);
      end else begin
         case (op_q)
            OP_AND:          res = a_q & b_q;
            OP_ORR:          res = a_q | b_q;
            OP_EOR:          res = a_q ^ b_q;
            OP_BIC:          res = a_q & ~b_q;
            OP_MOV:          res = b_q;
            OP_MVN:          res = ~b_q;
            OP_MUL, OP_UDIV: begin res = seq_result; c_out = cf_q; end
            default:         begin res = '0; c_out = 1'b0; end
         endcase
      end
   end

   // FSM next state, operand capture and output register updates.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      cf_d     = cf_q;
      sc_d     = sc_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         ST_ITER: begin
            if (seq_last) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
            end
         end
         ST_DONE: begin
            done_d   = 1'b1;
            result_d = res;
            flags_d  = {res[WIDTH-1], (res == '0), c_out, v_out};
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A new op may be accepted in IDLE or DONE (back-to-back issue).
      if (accept) begin
         op_d    = ALUOp;
         a_d     = Src_A;
         b_d     = Src_B;
         cf_d    = C_Flag;
         sc_d    = Shifter_carryOut;
         state_d = is_iter(ALUOp) ? ST_ITER : ST_DONE;
         busy_d  = is_iter(ALUOp);
      end
   end

   // State, captured operands and registered outputs.
   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cf_q     <= 1'b0;
         sc_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cf_q     <= cf_d;
         sc_q     <= sc_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   assign Busy      = busy_q;
   assign Done      = done_q;
   assign ALUResult = result_q;
   assign ALUFlags  = flags_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed corner cases plus randomized ops vs a reference model.
// Latency: checks 1 cycle for single-cycle ops and WIDTH+1 for MUL/UDIV.
// Backpressure: checks Busy duration and that Start during Busy is ignored.
`timescale 1ns/1ps
module tb_alu_multicycle;
   localparam int W = 32;

   localparam logic [3:0] T_ADD  = 4'h0;
   localparam logic [3:0] T_SUB  = 4'h1;
   localparam logic [3:0] T_SBC  = 4'h7;
   localparam logic [3:0] T_MOV  = 4'hA;
   localparam logic [3:0] T_MUL  = 4'hC;
   localparam logic [3:0] T_UDIV = 4'hD;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic         CLK = 1'b0;
   logic         RESETn;
   logic         Start;
   logic [3:0]   ALUOp;
   logic [W-1:0] Src_A, Src_B;
   logic         C_Flag, Shifter_carryOut;
   logic         Busy, Done;
   logic [W-1:0] ALUResult;
   logic [3:0]   ALUFlags;

   int tests = 0;
   int fails = 0;

   alu_multicycle #(.WIDTH(W)) dut (
      .CLK              (CLK),
      .RESETn           (RESETn),
      .Start            (Start),
      .ALUOp            (ALUOp),
      .Src_A            (Src_A),
      .Src_B            (Src_B),
      .C_Flag           (C_Flag),
      .Shifter_carryOut (Shifter_carryOut),
      .Busy             (Busy),
      .Done             (Done),
      .ALUResult        (ALUResult),
      .ALUFlags         (ALUFlags)
   );

   always #5 CLK = ~CLK;

   // Reference model from the ARM arithmetic definitions: returns {NZCV, result}.
   function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic sc);
      logic [63:0] ua, ub;
      longint      sa, sb, s, lc, lnb;
      logic [31:0] r;
      logic        cf, vf, arith;
      ua = {32'd0, a};
      ub = {32'd0, b};
      sa = $signed(a);
      sb = $signed(b);
      lc  = c ? 64'sd1 : 64'sd0;
      lnb = c ? 64'sd0 : 64'sd1;
      r = '0; cf = sc; vf = 1'b0; s = 0; arith = 1'b1;
      case (op)
         4'h0: begin r = a + b; cf = (ua + ub) >= 64'h1_0000_0000; s = sa + sb; end
         4'h1: begin r = a - b; cf = ua >= ub; s = sa - sb; end
         4'h5: begin r = b - a; cf = ub >= ua; s = sb - sa; end
         4'h6: begin r = a + b + {31'd0, c}; cf = (ua + ub + {63'd0, c}) >= 64'h1_0000_0000; s = sa + sb + lc; end
         4'h7: begin r = a - b - {31'd0, !c}; cf = ua >= (ub + {63'd0, !c}); s = sa - sb - lnb; end
         4'h8: begin r = b - a - {31'd0, !c}; cf = ub >= (ua + {63'd0, !c}); s = sb - sa - lnb; end
         default: begin
            arith = 1'b0;
            case (op)
               4'h2: r = a & b;
               4'h3: r = a | b;
               4'h4: r = a ^ b;
               4'h9: r = a & ~b;
               4'hA: r = b;
               4'hB: r = ~b;
               4'hC: begin r = a * b; cf = c; end
               4'hD: begin r = (b == 0) ? 32'd0 : a / b; cf = c; end
               default: begin r = '0; cf = 1'b0; end
            endcase
         end
      endcase
      if (arith) vf = (s > SMAX) || (s < SMIN);
      return {r[31], (r == 0), cf, vf, r};
   endfunction

   // Issue one op at the current negedge, scramble inputs after accept, measure until Done.
   // poke: cycle index (after accept) at which to assert a stray Start for one cycle (-1: none).
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic c, input logic sc, input int poke,
                         output int lat, output int bcnt, output logic [31:0] res,
                         output logic [3:0] fl, output bit ok);
      logic [31:0] rnd;
      ALUOp = op; Src_A = a; Src_B = b; C_Flag = c; Shifter_carryOut = sc; Start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      rnd = $urandom;
      Start = 1'b0; ALUOp = rnd[3:0]; C_Flag = rnd[4]; Shifter_carryOut = rnd[5];
      Src_A = $urandom; Src_B = $urandom;
      lat = 0; bcnt = 0; ok = 1'b0;
      while (lat < 100) begin
         if (Busy) bcnt++;
         if (Done) begin ok = 1'b1; break; end
         @(negedge CLK);
         lat++;
         Start = (lat == poke);
         if (lat == poke) ALUOp = T_ADD;
      end
      Start = 1'b0;
      res = ALUResult;
      fl  = ALUFlags;
   endtask

   task automatic test_reset;
      RESETn = 1'b0; Start = 1'b0; ALUOp = '0; Src_A = '0; Src_B = '0;
      C_Flag = 1'b0; Shifter_carryOut = 1'b0;
      repeat (2) @(negedge CLK);
      tests++;
      if ({Busy, Done} !== 2'b00) begin
         fails++; $display("FAIL reset_ctrl: Busy,Done=%b expected 00", {Busy, Done});
      end
      tests++;
      if ({ALUResult, ALUFlags} !== 36'd0) begin
         fails++; $display("FAIL reset_data: result=%h flags=%b expected 0/0000", ALUResult, ALUFlags);
      end
      RESETn = 1'b1;
      @(negedge CLK);
      tests++;
      if ({Busy, Done} !== 2'b00) begin
         fails++; $display("FAIL idle_after_reset: Busy,Done=%b expected 00", {Busy, Done});
      end
   endtask

   task automatic test_single_cycle;
      int lat, bcnt; logic [31:0] res; logic [3:0] fl; bit ok;
      run_op(T_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != 1 || bcnt != 0) begin
         fails++; $display("FAIL add_timing: ok=%0d lat=%0d busy=%0d expected 1/1/0", ok, lat, bcnt);
      end
      tests++;
      if (res !== 32'h80000000 || fl !== 4'b1001) begin
         fails++; $display("FAIL add_ovf: got %h/%b expected 80000000/1001", res, fl);
      end
      @(negedge CLK);
      tests++;
      if (Done !== 1'b0 || ALUResult !== 32'h80000000) begin
         fails++; $display("FAIL done_pulse: Done=%b result=%h expected 0/80000000", Done, ALUResult);
      end
      run_op(T_SUB, 32'd5, 32'd5, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || res !== 32'h0 || fl !== 4'b0110) begin
         fails++; $display("FAIL sub_zero: got %h/%b expected 00000000/0110", res, fl);
      end
      run_op(T_SBC, 32'd5, 32'd5, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || res !== 32'hFFFFFFFF || fl !== 4'b1000) begin
         fails++; $display("FAIL sbc_borrow: got %h/%b expected FFFFFFFF/1000", res, fl);
      end
      run_op(T_MOV, 32'h12345678, 32'd0, 1'b0, 1'b1, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || res !== 32'h0 || fl !== 4'b0110) begin
         fails++; $display("FAIL mov_carry: got %h/%b expected 00000000/0110", res, fl);
      end
   endtask

   task automatic test_mul;
      int lat, bcnt; logic [31:0] res; logic [3:0] fl; bit ok;
      run_op(T_MUL, 32'h0000FFFF, 32'h00010001, 1'b1, 1'b0, 5, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != W + 1 || bcnt != W) begin
         fails++; $display("FAIL mul_timing: ok=%0d lat=%0d busy=%0d expected 1/%0d/%0d", ok, lat, bcnt, W + 1, W);
      end
      tests++;
      if (res !== 32'hFFFFFFFF || fl !== 4'b1010) begin
         fails++; $display("FAIL mul_result: got %h/%b expected FFFFFFFF/1010", res, fl);
      end
      @(negedge CLK);
      tests++;
      if (Done !== 1'b0 || Busy !== 1'b0) begin
         fails++; $display("FAIL mul_ignored_start: Done=%b Busy=%b expected 0/0", Done, Busy);
      end
   endtask

   task automatic test_udiv_back_to_back;
      int lat, bcnt; logic [31:0] res; logic [3:0] fl; bit ok;
      logic [35:0] exp; logic [31:0] a, b;
      run_op(T_UDIV, 32'd100, 32'd7, 1'b0, 1'b1, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != W + 1 || res !== 32'h0000000E || fl !== 4'b0000) begin
         fails++; $display("FAIL udiv_100_7: lat=%0d got %h/%b expected %0d 0000000E/0000", lat, res, fl, W + 1);
      end
      run_op(T_UDIV, 32'd100, 32'd0, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != W + 1 || res !== 32'h0 || fl !== 4'b0100) begin
         fails++; $display("FAIL udiv_by_zero: lat=%0d got %h/%b expected %0d 00000000/0100", lat, res, fl, W + 1);
      end
      a = $urandom; b = $urandom;
      exp = model(T_ADD, a, b, 1'b0, 1'b0);
      run_op(T_ADD, a, b, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != 1 || {fl, res} !== exp) begin
         fails++; $display("FAIL back_to_back: lat=%0d got %b/%h expected 1 %b/%h", lat, fl, res, exp[35:32], exp[31:0]);
      end
   endtask

   task automatic test_reset_mid;
      int lat, bcnt; logic [31:0] res; logic [3:0] fl; bit ok; bit saw;
      run_op(T_ADD, 32'd1, 32'd2, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      @(negedge CLK);
      ALUOp = T_MUL; Src_A = 32'd3; Src_B = 32'd5; Start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      Start = 1'b0;
      repeat (10) @(negedge CLK);
      #1 RESETn = 1'b0;
      #1;
      tests++;
      if ({Busy, Done} !== 2'b00 || ALUResult !== 32'd0 || ALUFlags !== 4'd0) begin
         fails++; $display("FAIL reset_mid: Busy=%b Done=%b result=%h flags=%b expected all 0", Busy, Done, ALUResult, ALUFlags);
      end
      @(negedge CLK);
      RESETn = 1'b1;
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK);
         if (Done || Busy) saw = 1'b1;
      end
      tests++;
      if (saw) begin
         fails++; $display("FAIL reset_abort: Done/Busy seen=1 expected 0");
      end
      run_op(T_ADD, 32'd10, 32'd20, 1'b0, 1'b0, -1, lat, bcnt, res, fl, ok);
      tests++;
      if (!ok || lat != 1 || res !== 32'd30 || fl !== 4'b0000) begin
         fails++; $display("FAIL add_after_reset: lat=%0d got %h/%b expected 1 0000001E/0000", lat, res, fl);
      end
   endtask

   task automatic test_random;
      int lat, bcnt, poke, exp_lat; logic [31:0] res; logic [3:0] fl; bit ok;
      logic [35:0] exp; logic [31:0] a, b, rnd; logic [3:0] op; bit iter;
      for (int n = 0; n < 150; n++) begin
         rnd = $urandom;
         op = rnd[3:0];
         a = $urandom; b = $urandom;
         if (rnd[5:4] == 2'b00) b = $urandom_range(0, 20);
         if (rnd[7:6] == 2'b00) a = $urandom_range(0, 300);
         iter = (op == T_MUL) || (op == T_UDIV);
         poke = (iter && rnd[8]) ? int'($urandom_range(1, W - 1)) : -1;
         exp = model(op, a, b, rnd[9], rnd[10]);
         exp_lat = iter ? W + 1 : 1;
         run_op(op, a, b, rnd[9], rnd[10], poke, lat, bcnt, res, fl, ok);
         tests++;
         if ({fl, res} !== exp) begin
            fails++; $display("FAIL rand_result op=%h a=%h b=%h c=%b: got %b/%h expected %b/%h",
                              op, a, b, rnd[9], fl, res, exp[35:32], exp[31:0]);
         end
         tests++;
         if (!ok || lat != exp_lat || bcnt != (iter ? W : 0)) begin
            fails++; $display("FAIL rand_timing op=%h: ok=%0d lat=%0d busy=%0d expected 1/%0d/%0d",
                              op, ok, lat, bcnt, exp_lat, iter ? W : 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_mul();
      test_udiv_back_to_back();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
